alu_iterative: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shift_iter.sv | 59 +++++
 rtl/alu_iterative.sv | 114 +++++++++++
 tb/tb_alu_iterative.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and FSM state encoding
//
// Purpose : op-code localparams shared with the ALU control decoder, the
//           iterative ALU FSM encoding, and a shift-op classifier.
// Ports   : none (package).
package alu_pkg;

  localparam logic [2:0] ALU_SUM = 3'd0;
  localparam logic [2:0] ALU_SLT = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SRA = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SRA) || (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - one-bit-per-cycle shifter for the iterative ALU
//
// Purpose : shift register plus shamt counter. Loaded on start, then moves
//           one bit position per clock until the counter reaches zero.
// Ports   : clk, rst_n     clock, async active-low reset
//           start          load a/shamt/direction (only with shamt > 0)
//           op             shift op code (SRA/SLL/SRL) captured at start
//           a              shift source
//           shamt          shift amount
//           next_data      value the register takes at the next edge
//           done           high during the cycle whose edge finishes the shift
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2:0]              op,
  input  logic [XLEN-1:0]         a,
  input  logic [$clog2(XLEN)-1:0] shamt,
  output logic [XLEN-1:0]         next_data,
  output logic                    done
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] data_q;
  logic [SW-1:0]   count_q;
  logic            left_q;
  logic            fill_q;

  // Fill bit is resolved once at load time: sign bit for SRA, zero otherwise.
  assign next_data = left_q ? {data_q[XLEN-2:0], 1'b0}
                            : {fill_q, data_q[XLEN-1:1]};

  // The counter sits at 0 whenever no shift is in flight, so count == 1
  // marks the final shifting edge.
  assign done = (count_q == SW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      left_q  <= 1'b0;
      fill_q  <= 1'b0;
    end else if (start) begin
      data_q  <= a;
      count_q <= shamt;
      left_q  <= (op == ALU_SLL);
      fill_q  <= (op == ALU_SRA) && a[XLEN-1];
    end else if (count_q != '0) begin
      data_q  <= next_data;
      count_q <= count_q - SW'(1);
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - registered ALU with iterative shifts and valid/ready
//
// Purpose : single-cycle SUM/SLT/AND/OR/XOR, bit-serial SRA/SLL/SRL, result
//           held in DONE until the consumer takes it.
// Ports   : clk, rst_n              clock, async active-low reset
//           in_valid, in_ready     request handshake (in_ready = IDLE)
//           op, sub, cmp_unsigned  operation select and modifiers
//           a, b                   operands (shifts use b[log2(XLEN)-1:0])
//           out_valid, out_ready   result handshake
//           result, zero           registered result and (result == 0)
module alu_iterative
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            sub,
  input  logic            cmp_unsigned,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);

  state_t          state;
  logic [SW-1:0]   shamt;
  logic            accept;
  logic            start_shift;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] b_eff;
  logic            lt;
  logic [XLEN-1:0] sh_next;
  logic            sh_done;

  assign in_ready    = (state == IDLE);
  assign shamt       = b[SW-1:0];
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift_op(op) && (shamt != '0);

  // Subtract as a + ~b + 1 so one adder serves both directions.
  assign b_eff = sub ? ~b : b;
  assign lt    = cmp_unsigned ? (a < b) : ($signed(a) < $signed(b));

  always_comb begin
    alu_y = a;
    case (op)
      ALU_SUM: alu_y = a + b_eff + {{(XLEN-1){1'b0}}, sub};
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, lt};
      ALU_AND: alu_y = a & b;
      ALU_OR:  alu_y = a | b;
      ALU_XOR: alu_y = a ^ b;
      default: alu_y = a;  // shift by zero completes immediately with a
    endcase
  end

  alu_shift_iter #(.XLEN(XLEN)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_shift),
    .op        (op),
    .a         (a),
    .shamt     (shamt),
    .next_data (sh_next),
    .done      (sh_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              state <= SHIFT;
            end else begin
              result    <= alu_y;
              zero      <= (alu_y == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          if (sh_done) begin
            result    <= sh_next;
            zero      <= (sh_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - directed self-checking bench for alu_iterative
module tb_alu_iterative;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        sub;
  logic        cmp_unsigned;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int tests;
  int fails;

  alu_iterative #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .sub          (sub),
    .cmp_unsigned (cmp_unsigned),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        sub;
    logic        cu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge. Drives one request, scrambles the inputs
  // after the accept edge, measures latency and completes the handshake.
  task automatic run_op(input int idx, input vec_t v);
    int  w;
    int  lat;
    bit  got;
    bit  ready_low;
    string tag;
    tag = $sformatf("vec%0d", idx);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid     = 1'b1;
    op           = v.op;
    sub          = v.sub;
    cmp_unsigned = v.cu;
    a            = v.a;
    b            = v.b;
    lat       = 0;
    got       = 1'b0;
    ready_low = 1'b1;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      in_valid     = 1'b0;
      op           = 3'($urandom_range(0, 7));
      sub          = 1'($urandom_range(0, 1));
      cmp_unsigned = 1'($urandom_range(0, 1));
      a            = $urandom;
      b            = $urandom;
      if (out_valid) got = 1'b1;
      else if (in_ready) ready_low = 1'b0;
    end
    check({tag, " out_valid"}, 32'(got), 32'd1);
    check({tag, " result"}, result, v.res);
    check({tag, " zero"}, 32'(zero), 32'(v.z));
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " in_ready low while busy"}, 32'(ready_low), 32'd1);
    check({tag, " in_ready low in DONE"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] hold_res;
    logic        hold_z;
    bit          stable;
    bit          seen;
    int          w;
    vec_t        xv;

    tests = 0;
    fails = 0;

    //          op  sub cu a             b             result        z     lat
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0, 1};
    vecs[1]  = '{3'd0, 1'b1, 1'b0, 32'd5,        32'd5,        32'd0,        1'b1, 1};
    vecs[2]  = '{3'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1};
    vecs[3]  = '{3'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1};
    vecs[4]  = '{3'd6, 1'b0, 1'b0, 32'd1,        32'd31,       32'h80000000, 1'b0, 32};
    vecs[5]  = '{3'd6, 1'b0, 1'b0, 32'h00001234, 32'd0,        32'h00001234, 1'b0, 1};
    vecs[6]  = '{3'd6, 1'b0, 1'b0, 32'h00001234, 32'h21,       32'h00002468, 1'b0, 2};
    vecs[7]  = '{3'd5, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 5};
    vecs[8]  = '{3'd7, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 5};
    vecs[9]  = '{3'd2, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1};
    vecs[10] = '{3'd3, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0, 1};
    vecs[11] = '{3'd4, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1};
    vecs[12] = '{3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1};
    vecs[13] = '{3'd0, 1'b1, 1'b0, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1};
    vecs[14] = '{3'd1, 1'b0, 1'b1, 32'd5,        32'hFFFFFFFD, 32'd1,        1'b0, 1};
    vecs[15] = '{3'd5, 1'b0, 1'b0, 32'h40000000, 32'd30,       32'd1,        1'b0, 31};

    // Reset, with a request asserted that must be ignored.
    rst_n        = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    op           = 3'd0;
    sub          = 1'b0;
    cmp_unsigned = 1'b0;
    a            = 32'd9;
    b            = 32'd9;
    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", 32'(zero), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("post reset out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 16; i++) run_op(i, vecs[i]);

    // Backpressure: SUM 3+4 held 5 cycles while a XOR request waits.
    in_valid = 1'b1;
    op = 3'd0; sub = 1'b0; cmp_unsigned = 1'b0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    op = 3'd4; a = 32'h0000F0F0; b = 32'h00000FF0;
    check("bp out_valid", 32'(out_valid), 32'd1);
    check("bp result", result, 32'd7);
    hold_res = result;
    hold_z   = zero;
    stable   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== hold_res || zero !== hold_z) stable = 1'b0;
    end
    check("bp held stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp in_ready after take", 32'(in_ready), 32'd1);
    check("bp out_valid after take", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next op out_valid", 32'(out_valid), 32'd1);
    check("bp next op result", result, 32'h0000FF00);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a 20-bit SRL.
    in_valid = 1'b1;
    op = 3'd7; a = 32'hFFFFFFFF; b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midshift busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midshift reset out_valid", 32'(out_valid), 32'd0);
    check("midshift reset result", result, 32'd0);
    check("midshift reset zero", 32'(zero), 32'd1);
    check("midshift reset in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    w = 0;
    while (w < 25) begin
      @(negedge clk);
      w++;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("aborted shift produced nothing", 32'(seen), 32'd0);
    xv = '{3'd4, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1};
    run_op(99, xv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
